i2c_tx_scheduler: RTL and testbench
===================================

# i2c_tx_scheduler

Round-robin scheduler that shares the peripheral's single byte transmitter between several on-chip byte sources (ZeroOne, OneZero, FNV-1a, bad-address responder). It accepts one byte per grant from the winning requester, drives the transmitter's enable/data for exactly eight bit-times, and steers the pad direction mask. It then leaves a one-cycle ACK slot before the next grant. It sits between the address/dispatch FSM's per-peripheral sources and `byte_transmitter`, in the SCL clock domain.

## Interface
- `NUM_REQ`, default 4: number of byte sources; legal range 2..8.
- `BITS_PER_BYTE`, default 8: bit-times per transmitted byte.
- `clk` in 1: SCL-derived clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `req` in NUM_REQ: source i has a byte pending; held high with stable data until granted.
- `req_data` in 8*NUM_REQ: packed bytes, source i at bits [8i+7:8i].
- `abort` in 1: stop/bus error detected; abandon the current byte.
- `grant` out NUM_REQ: one-hot, one-cycle pulse marking which source's byte was latched.
- `tx_enable` out 1: drives `byte_transmitter.enable`.
- `tx_byte` out 8: drives `byte_transmitter.in`.
- `direction` out 8: 8'h20 (WriteMask) while shifting, else 8'h00 (ReadMask).
- `busy` out 1: high whenever state is not IDLE.
- `bytes_sent` out 8: saturating count of completed bytes.

## Operation
- States: IDLE, SHIFT, ACK_SLOT.
- IDLE: if `abort`=0 and any `req` is high, pick a winner round-robin, searching from `last_idx+1` mod NUM_REQ upward.
  - Register `tx_byte`←winner data, `tx_enable`←1, `direction`←8'h20, `grant`←onehot(winner), `last_idx`←winner, `bit_cnt`←0.
  - Go to SHIFT.
- SHIFT: `bit_cnt` increments each cycle. At `bit_cnt`=BITS_PER_BYTE-1:
  - `tx_enable`←0, `direction`←8'h00.
  - `bytes_sent`←min(`bytes_sent`+1, 255).
  - Go to ACK_SLOT.
- ACK_SLOT: one cycle, outputs idle, go to IDLE. The bus master ACKs here; the scheduler does not sample it.
- `grant` is high only in the first SHIFT cycle and is zero otherwise.
- `tx_byte` holds its value until the next grant. It does not change mid-byte even if the source changes `req_data`.
- A source that drops `req` before being granted is skipped silently.
- Abort has priority over everything:
  - In SHIFT or ACK_SLOT: next cycle is IDLE, `tx_enable`=0, `direction`=8'h00, `grant`=0, no `bytes_sent` increment.
  - In IDLE: no grant that cycle, even if `req` is high.
  - `last_idx` keeps the aborted winner's index.
- Reset values:
  - state IDLE, `grant`=0, `tx_enable`=0, `tx_byte`=8'h00, `direction`=8'h00, `busy`=0, `bytes_sent`=0.
  - `last_idx`=NUM_REQ-1, so source 0 has first priority.
- Reset mid-byte: same as abort, and also clears `bytes_sent` and `last_idx`.

## Timing
- Request seen in IDLE at cycle t gives `grant`, `tx_enable` and `direction`=8'h20 in cycle t+1.
- `tx_enable` is high for exactly BITS_PER_BYTE cycles (t+1..t+8 at default).
- ACK_SLOT is cycle t+9; IDLE is cycle t+10.
- Back-to-back throughput: one byte per BITS_PER_BYTE+2 cycles (10 at default).
- `abort` sampled at edge n gives an idle output state in cycle n+1 (one-cycle latency).
- All outputs are registered; there are no combinational paths from `req`/`abort` to any output.

## Structure
- Shared header `i2c_consts.v`, guarded by `ifndef`, holds ReadMask, WriteMask and this block's state encodings. The direction masks there are reused by `i2c_periph`.
- One sub-module, `rr_arbiter`: combinational round-robin picker taking (`req`, `last_idx`) and returning (`valid`, `winner_idx`, `onehot`), parameterised by NUM_REQ.
- `bit_cnt` is width $clog2(BITS_PER_BYTE)+1.

## Test plan
- After reset, `req`=4'b0001, `req_data[7:0]`=8'h55 → `grant`=4'b0001 one cycle later; `tx_byte`=8'h55; `tx_enable` high exactly 8 cycles; `direction` 8'h20 over the same window; `bytes_sent`=1.
- `req`=4'b1111 held continuously, data 8'hA0..8'hA3 → grants in order 0,1,2,3,0 at 10-cycle spacing; no byte repeated before the others are served.
- `req`=4'b0110 with `last_idx`=1 → source 2 is granted before source 1.
- `abort` pulsed on the 4th SHIFT cycle → `tx_enable`/`direction` drop next cycle; `busy`=0; `bytes_sent` unchanged; a pending source is granted on the following IDLE cycle.
- `abort` and `req`=4'b0001 together in IDLE → no grant that cycle; grant one cycle after `abort` falls.
- Send 260 bytes → `bytes_sent` saturates at 255. Reset asserted mid-SHIFT → all outputs at reset values next cycle.

Source files
------------

// File: rtl/i2c_tx_scheduler_pkg.sv
// Shared constants and types for the I2C byte-transmit scheduler.
// Direction masks are also used by the peripheral pad logic.
package i2c_tx_scheduler_pkg;

    localparam logic [7:0] READ_MASK  = 8'h00;
    localparam logic [7:0] WRITE_MASK = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACK   = 2'd2
    } sched_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_idx+1.
// Returns the winner as both an index and a one-hot vector.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               valid,
    output logic [IDX_W-1:0]   winner_idx,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        valid      = 1'b0;
        winner_idx = '0;
        onehot     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_idx) + k) % NUM_REQ;
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                winner_idx  = IDX_W'(idx);
                onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_tx_scheduler.sv
// Shares one byte transmitter between several byte sources, round-robin.
// Each grant drives eight bit-times of shifting, then a one-cycle ACK slot.
import i2c_tx_scheduler_pkg::*;

module i2c_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int BITS_PER_BYTE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic                 abort,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_enable,
    output logic [7:0]           tx_byte,
    output logic [7:0]           direction,
    output logic                 busy,
    output logic [7:0]           bytes_sent
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BITS_PER_BYTE) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_BYTE - 1);

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               tx_enable_d;
    logic [7:0]         tx_byte_d, direction_d, bytes_sent_d;

    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [7:0]         win_byte;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req        (req),
        .last_idx   (last_idx_q),
        .valid      (arb_valid),
        .winner_idx (arb_idx),
        .onehot     (arb_onehot)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_onehot[i]) win_byte = req_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_idx_d   = last_idx_q;
        bit_cnt_d    = bit_cnt_q;
        grant_d      = '0;
        tx_enable_d  = tx_enable;
        tx_byte_d    = tx_byte;
        direction_d  = direction;
        bytes_sent_d = bytes_sent;
        unique case (state_q)
            ST_IDLE: begin
                if (!abort && arb_valid) begin
                    state_d     = ST_SHIFT;
                    last_idx_d  = arb_idx;
                    bit_cnt_d   = '0;
                    grant_d     = arb_onehot;
                    tx_enable_d = 1'b1;
                    tx_byte_d   = win_byte;
                    direction_d = WRITE_MASK;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    tx_enable_d = 1'b0;
                    direction_d = READ_MASK;
                end else if (bit_cnt_q == LAST_BIT) begin
                    state_d      = ST_ACK;
                    tx_enable_d  = 1'b0;
                    direction_d  = READ_MASK;
                    bytes_sent_d = sat_inc8(bytes_sent);
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                tx_enable_d = 1'b0;
                direction_d = READ_MASK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_idx_q <= IDX_W'(NUM_REQ - 1);
            bit_cnt_q  <= '0;
            grant      <= '0;
            tx_enable  <= 1'b0;
            tx_byte    <= 8'h00;
            direction  <= READ_MASK;
            busy       <= 1'b0;
            bytes_sent <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_idx_q <= last_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            grant      <= grant_d;
            tx_enable  <= tx_enable_d;
            tx_byte    <= tx_byte_d;
            direction  <= direction_d;
            busy       <= (state_d != ST_IDLE);
            bytes_sent <= bytes_sent_d;
        end
    end

endmodule

// File: tb/tb_i2c_tx_scheduler.sv
// Randomised and directed bench for i2c_tx_scheduler.
// A transaction-level reference model predicts every output each cycle.
module tb_i2c_tx_scheduler;

    localparam int N   = 4;
    localparam int BPB = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic           abort = 1'b0;
    logic [N-1:0]   grant;
    logic           tx_enable;
    logic [7:0]     tx_byte;
    logic [7:0]     direction;
    logic           busy;
    logic [7:0]     bytes_sent;

    i2c_tx_scheduler #(.NUM_REQ(N), .BITS_PER_BYTE(BPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .abort      (abort),
        .grant      (grant),
        .tx_enable  (tx_enable),
        .tx_byte    (tx_byte),
        .direction  (direction),
        .busy       (busy),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0 idle, 1..BPB shifting bit-times, BPB+1 ack slot
    int           m_phase = 0;
    int           m_last  = N - 1;
    int           m_sent  = 0;
    logic [7:0]   m_byte  = 8'h00;
    logic [N-1:0] m_grant = '0;

    wire [29:0] dut_vec = {grant, tx_enable, tx_byte, direction, busy, bytes_sent};

    function automatic logic [29:0] exp_vec();
        logic en;
        en = (m_phase >= 1) && (m_phase <= BPB);
        return {m_grant, en, m_byte, (en ? 8'h20 : 8'h00),
                (m_phase != 0), 8'(m_sent)};
    endfunction

    task automatic model_step();
        if (reset) begin
            m_phase = 0; m_last = N - 1; m_sent = 0;
            m_byte = 8'h00; m_grant = '0;
        end else begin
            m_grant = '0;
            if (m_phase == 0) begin
                if (!abort) begin
                    for (int k = 1; k <= N; k++) begin
                        int w;
                        w = (m_last + k) % N;
                        if (req[w]) begin
                            m_byte = req_data[8*w +: 8];
                            m_last = w;
                            m_grant[w] = 1'b1;
                            m_phase = 1;
                            break;
                        end
                    end
                end
            end else if (abort) begin
                m_phase = 0;
            end else if (m_phase < BPB) begin
                m_phase++;
            end else if (m_phase == BPB) begin
                m_phase = BPB + 1;
                if (m_sent < 255) m_sent++;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; abort = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_tests++;
        if (dut_vec !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", dut_vec, 30'h0);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int en_cnt = 0;
        int dir_cnt = 0;
        req_data[7:0] = 8'h55;
        req = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (grant != '0) req = '0;
            if (tx_enable) en_cnt++;
            if (direction == 8'h20) dir_cnt++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL single cyc%0d got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 0) begin
                n_tests++;
                if (grant !== 4'b0001 || tx_byte !== 8'h55) begin
                    n_fail++;
                    $display("FAIL single_grant got %b/%h want 0001/55", grant, tx_byte);
                end
            end
        end
        n_tests++;
        if (en_cnt != 8 || dir_cnt != 8 || bytes_sent !== 8'd1) begin
            n_fail++;
            $display("FAIL single_window got en=%0d dir=%0d sent=%0d want 8 8 1",
                     en_cnt, dir_cnt, bytes_sent);
        end
    endtask

    task automatic test_round_robin();
        int gidx[$];
        int gcyc[$];
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req = 4'b1111;
        for (int i = 0; i < 45; i++) begin
            tick();
            for (int j = 0; j < N; j++) begin
                if (grant[j]) begin gidx.push_back(j); gcyc.push_back(i); end
            end
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr cyc%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (gidx.size() < 5) begin
            n_fail++;
            $display("FAIL rr_count got %0d want 5", gidx.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_tests++;
                if (gidx[k] != k % N || (k > 0 && gcyc[k] - gcyc[k-1] != BPB + 2)) begin
                    n_fail++;
                    $display("FAIL rr_order k%0d got idx%0d gap%0d want idx%0d gap%0d",
                             k, gidx[k], (k > 0) ? gcyc[k] - gcyc[k-1] : 0,
                             k % N, BPB + 2);
                end
            end
        end
        req = '0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_priority();
        logic [N-1:0] first = '0;
        logic [N-1:0] second = '0;
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b0010;
        tick();
        req = '0;
        for (int i = 0; i < 12; i++) tick();
        req = 4'b0110;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (grant != '0) begin
                if (first == '0) first = grant; else if (second == '0) second = grant;
                req = req & ~grant;
            end
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL prio cyc%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (first !== 4'b0100 || second !== 4'b0010) begin
            n_fail++;
            $display("FAIL prio_order got %b,%b want 0100,0010", first, second);
        end
    endtask

    task automatic test_abort_shift();
        do_reset();
        req_data = {8'h00, 8'h00, 8'hBB, 8'hAA};
        req = 4'b0011;
        tick();
        req = 4'b0010;
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if (tx_enable !== 1'b0 || direction !== 8'h00 || busy !== 1'b0 ||
            bytes_sent !== 8'd0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL abort_shift got %h want %h", dut_vec, exp_vec());
        end
        tick();
        n_tests++;
        if (grant !== 4'b0010 || tx_byte !== 8'hBB || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL abort_regrant got %b/%h want 0010/bb", grant, tx_byte);
        end
        req = '0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_abort_idle();
        do_reset();
        req_data[7:0] = 8'h5A;
        req = 4'b0001;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if (grant !== 4'b0000 || busy !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL abort_idle got %h want %h", dut_vec, exp_vec());
        end
        tick();
        req = '0;
        n_tests++;
        if (grant !== 4'b0001 || tx_byte !== 8'h5A || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL abort_idle_grant got %b/%h want 0001/5a", grant, tx_byte);
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset_mid();
        req_data[7:0] = 8'hC3;
        req = 4'b0001;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = '0;
        n_tests++;
        if (dut_vec !== 30'h0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_mid got %h want %h", dut_vec, 30'h0);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        req_data = {8'h04, 8'h03, 8'h02, 8'h01};
        req = 4'b1111;
        for (int i = 0; i < 260 * (BPB + 2) + 2; i++) begin
            tick();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat cyc%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (bytes_sent !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_count got %0d want 255", bytes_sent);
        end
        req = '0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            req      = N'($urandom);
            req_data = $urandom;
            abort    = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 149) == 0);
            tick();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand cyc%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        reset = 1'b0; abort = 1'b0; req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_abort_shift();
        test_abort_idle();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
